// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters.
// Produces a registered one-hot grant and mux select, and caps how long one owner can hold the mux.
module mux_4to1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] Sel,
  output logic       gnt_valid,
  output logic       gnt_switch
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             switch_q, switch_d;

  logic             doGrant;
  logic [1:0]       searchFrom;
  logic [1:0]       grantIdx;
  logic [3:0]       ownerMask;
  logic [3:0]       othersReq;

  // First requester at or after s, wrapping mod 4; descending loop lets the nearest offset win.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] idx;
    pick = s;
    for (int j = 3; j >= 0; j--) begin
      idx = s + 2'(j);
      if (r[idx]) begin
        pick = idx;
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    switch_d   = 1'b0;
    doGrant    = 1'b0;
    searchFrom = ptr_q;
    ownerMask  = 4'b0001 << sel_q;
    othersReq  = req & ~ownerMask;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          doGrant    = 1'b1;
          searchFrom = ptr_q;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          ptr_d = sel_q + 2'd1;
          if (|othersReq) begin
            doGrant    = 1'b1;
            searchFrom = sel_q + 2'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q >= HoldMax) begin
          // Owner used its full quota: hand over only if someone else is waiting.
          if (|othersReq) begin
            ptr_d      = sel_q + 2'd1;
            doGrant    = 1'b1;
            searchFrom = sel_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    grantIdx = pick(req, searchFrom);
    if (doGrant) begin
      state_d  = BUSY;
      gnt_d    = 4'b0001 << grantIdx;
      sel_d    = grantIdx;
      valid_d  = 1'b1;
      switch_d = 1'b1;
      hold_d   = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      hold_q   <= '0;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
    end
  end

  assign gnt        = gnt_q;
  assign Sel        = sel_q;
  assign gnt_valid  = valid_q;
  assign gnt_switch = switch_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for mux_4to1_rr_arbiter: directed scenarios plus randomized requests against
// an integer-level model of owner, pointer and hold count.
module tb_mux_4to1_rr_arbiter;

  localparam int MaxHold = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] Sel;
  logic       gnt_valid;
  logic       gnt_switch;

  int vectors     = 0;
  int miscompares = 0;

  int mOwner;
  int mPtr;
  int mHold;
  int mSel;
  bit mSwitch;

  mux_4to1_rr_arbiter #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .Sel       (Sel),
    .gnt_valid (gnt_valid),
    .gnt_switch(gnt_switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pickModel(input logic [3:0] r, input int s);
    for (int off = 0; off < 4; off++) begin
      if (r[(s + off) % 4]) return (s + off) % 4;
    end
    return -1;
  endfunction

  task automatic resetModel();
    mOwner  = -1;
    mPtr    = 0;
    mHold   = 0;
    mSel    = 0;
    mSwitch = 0;
  endtask

  // Advances the model by one clock edge given the request vector sampled on it.
  task automatic stepModel(input logic [3:0] r);
    logic [3:0] others;
    mSwitch = 0;
    if (mOwner < 0) begin
      if (r != 4'b0000) begin
        mOwner  = pickModel(r, mPtr);
        mHold   = 1;
        mSwitch = 1;
      end
    end else begin
      others = r & ~(4'(1 << mOwner));
      if (!r[mOwner]) begin
        mPtr = (mOwner + 1) % 4;
        if (others != 4'b0000) begin
          mOwner  = pickModel(r, mPtr);
          mHold   = 1;
          mSwitch = 1;
        end else begin
          mOwner = -1;
          mHold  = 0;
        end
      end else if (mHold >= MaxHold && others != 4'b0000) begin
        mPtr    = (mOwner + 1) % 4;
        mOwner  = pickModel(r, mPtr);
        mHold   = 1;
        mSwitch = 1;
      end else if (mHold < MaxHold) begin
        mHold++;
      end
    end
    if (mOwner >= 0) mSel = mOwner;
  endtask

  function automatic logic [7:0] modelOutputs();
    logic [3:0] g;
    g = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    return {g, 2'(mSel), mOwner >= 0, mSwitch};
  endfunction

  task automatic applyCycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    stepModel(r);
    #1;
  endtask

  task automatic doReset();
    req   = 4'b0000;
    rst_n = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    req   = 4'b0000;
    rst_n = 1'b0;
    resetModel();
    #2;
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0000_00_0_0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, 8'b0000_00_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] obs, exp;
    doReset();
    for (int c = 1; c <= 3; c++) begin
      applyCycle(4'b0001);
      obs = {gnt, Sel, gnt_valid, gnt_switch};
      exp = {4'b0001, 2'b00, 1'b1, c == 1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL single_hold cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    applyCycle(4'b0000);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0000_00_0_0) begin
      miscompares++;
      $display("[TB] FAIL single_release: got %b expected %b", obs, 8'b0000_00_0_0);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] obs, exp;
    int owner;
    doReset();
    for (int c = 1; c <= 20; c++) begin
      applyCycle(4'b1111);
      owner = ((c - 1) / MaxHold) % 4;
      obs = {gnt, Sel, gnt_valid, gnt_switch};
      exp = {4'(1 << owner), 2'(owner), 1'b1, ((c - 1) % MaxHold) == 0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL rotation cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_first_grant();
    logic [7:0] obs;
    doReset();
    applyCycle(4'b0100);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0100_10_1_1) begin
      miscompares++;
      $display("[TB] FAIL first_grant: got %b expected %b", obs, 8'b0100_10_1_1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs;
    doReset();
    applyCycle(4'b0010);
    applyCycle(4'b1011);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0010_01_1_0) begin
      miscompares++;
      $display("[TB] FAIL handoff_setup: got %b expected %b", obs, 8'b0010_01_1_0);
    end
    applyCycle(4'b1001);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b1000_11_1_1) begin
      miscompares++;
      $display("[TB] FAIL handoff_to_3: got %b expected %b", obs, 8'b1000_11_1_1);
    end
    applyCycle(4'b0001);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0001_00_1_1) begin
      miscompares++;
      $display("[TB] FAIL handoff_to_0: got %b expected %b", obs, 8'b0001_00_1_1);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] obs, exp;
    doReset();
    for (int c = 1; c <= 10; c++) begin
      applyCycle(4'b0010);
      obs = {gnt, Sel, gnt_valid, gnt_switch};
      exp = {4'b0010, 2'b01, 1'b1, c == 1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL saturate cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    applyCycle(4'b0011);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0001_00_1_1) begin
      miscompares++;
      $display("[TB] FAIL saturate_preempt: got %b expected %b", obs, 8'b0001_00_1_1);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs;
    doReset();
    for (int c = 0; c < 3; c++) applyCycle(4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0000_00_0_0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b expected %b", obs, 8'b0000_00_0_0);
    end
    resetModel();
    req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    applyCycle(4'b1100);
    obs = {gnt, Sel, gnt_valid, gnt_switch};
    vectors++;
    if (obs !== 8'b0100_10_1_1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_grant: got %b expected %b", obs, 8'b0100_10_1_1);
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, exp;
    logic [3:0] r;
    doReset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      // Sparse phases give idle gaps and releases; dense phases exercise preemption.
      if ((c / 50) % 2 == 0) r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      else r = 4'($urandom_range(0, 15));
      applyCycle(r);
      obs = {gnt, Sel, gnt_valid, gnt_switch};
      exp = modelOutputs();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL random cycle %0d req %b: got %b expected %b", c, r, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    resetModel();
    test_reset();
    test_single();
    test_rotation();
    test_first_grant();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
